// File: rtl/cpu_mem_responder_pkg.sv
// Shared definitions for the CPU memory responder: IO window map, owner states, status bits.
package robin_mem_defs;

   typedef enum logic [0:0] {
      ST_CPU  = 1'b0,
      ST_HOST = 1'b1
   } state_t;

   localparam logic [2:0] IO_CNT    = 3'd0;
   localparam logic [2:0] IO_LED    = 3'd4;
   localparam logic [2:0] IO_STATUS = 3'd5;

   localparam int STAT_GRANT = 0;
   localparam int STAT_ERR   = 1;

   function automatic logic [7:0] status_byte(input logic grant, input logic err);
      logic [7:0] b;
      b             = 8'h00;
      b[STAT_GRANT] = grant;
      b[STAT_ERR]   = err;
      return b;
   endfunction

endpackage

// File: rtl/cpu_mem_responder_byte_ram.sv
// Simple-dual-port byte RAM with a registered, enabled read port; contents are never reset.
module byte_ram #(
   parameter int addr_width = 9
) (
   input  logic                  clk,
   input  logic                  rd_en,
   input  logic [addr_width-1:0] rd_addr,
   output logic [7:0]            rd_data,
   input  logic                  wr_en,
   input  logic [addr_width-1:0] wr_addr,
   input  logic [7:0]            wr_data
);

   logic [7:0] mem_r [0:(2**addr_width)-1];

   // Read samples the array before the write lands, so a same-address access returns the old byte.
   always_ff @(posedge clk) begin
      if (rd_en) begin
         rd_data <= mem_r[rd_addr];
      end
      if (wr_en) begin
         mem_r[wr_addr] <= wr_data;
      end
   end

endmodule

// File: rtl/cpu_mem_responder.sv
// Memory-side responder: byte RAM, IO window (counter snapshot, LED, status) and CPU/host port ownership.
module cpu_mem_responder
   import robin_mem_defs::*;
#(
   parameter int addr_width = 9
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [addr_width-1:0] cpu_raddr,
   input  logic [addr_width-1:0] cpu_waddr,
   input  logic [7:0]            cpu_wdata,
   input  logic                  cpu_write,
   output logic [7:0]            cpu_rdata,
   output logic                  cpu_ready,
   input  logic                  host_req,
   input  logic [addr_width-1:0] host_addr,
   input  logic [7:0]            host_wdata,
   input  logic                  host_write,
   input  logic                  host_read,
   output logic [7:0]            host_rdata,
   output logic                  host_valid,
   output logic                  host_grant,
   output logic [7:0]            led
);

   localparam int MEM_BYTES = 2**addr_width;
   localparam logic [addr_width-1:0] IO_BASE = addr_width'(MEM_BYTES - 8);

   state_t                state_r;
   logic                  cpu_ready_r;
   logic                  host_grant_r;
   logic                  host_valid_r;
   logic                  is_host_s;

   logic                  rd_en_s;
   logic [addr_width-1:0] rd_addr_s;
   logic                  wr_en_s;
   logic [addr_width-1:0] wr_addr_s;
   logic [7:0]            wr_data_s;
   logic                  rd_io_s;
   logic                  wr_io_s;
   logic [2:0]            rd_ofs_s;
   logic [2:0]            wr_ofs_s;
   logic                  ram_wr_s;
   logic [7:0]            ram_q_s;
   logic [7:0]            io_byte_s;
   logic                  drop_s;
   logic                  clr_s;

   logic [31:0]           counter_r;
   logic [31:0]           snapshot_r;
   logic [7:0]            led_r;
   logic                  err_r;
   logic                  src_io_r;
   logic [7:0]            io_q_r;
   logic                  cpu_upd_r;
   logic [7:0]            cpu_last_r;
   logic [7:0]            host_last_r;
   logic [7:0]            rd_fresh_s;
   logic [7:0]            cpu_rdata_s;
   logic [7:0]            host_rdata_s;

   assign is_host_s = (state_r == ST_HOST);

   // Route the current owner's address, data and strobes to RAM and IO.
   always_comb begin
      if (is_host_s) begin
         rd_en_s   = host_read;
         rd_addr_s = host_addr;
         wr_en_s   = host_write;
         wr_addr_s = host_addr;
         wr_data_s = host_wdata;
      end else begin
         rd_en_s   = 1'b1;
         rd_addr_s = cpu_raddr;
         wr_en_s   = cpu_write;
         wr_addr_s = cpu_waddr;
         wr_data_s = cpu_wdata;
      end
   end

   assign rd_io_s  = (rd_addr_s >= IO_BASE);
   assign wr_io_s  = (wr_addr_s >= IO_BASE);
   assign rd_ofs_s = rd_addr_s[2:0];
   assign wr_ofs_s = wr_addr_s[2:0];
   assign ram_wr_s = wr_en_s & ~wr_io_s;
   assign drop_s   = is_host_s & cpu_write;
   assign clr_s    = wr_en_s & wr_io_s & (wr_ofs_s == IO_STATUS) & wr_data_s[STAT_ERR];

   // IO window read byte; offset 0 returns the live counter top byte that is being snapshotted.
   always_comb begin
      io_byte_s = 8'h00;
      case (rd_ofs_s)
         IO_CNT:    io_byte_s = counter_r[31:24];
         3'd1:      io_byte_s = snapshot_r[23:16];
         3'd2:      io_byte_s = snapshot_r[15:8];
         3'd3:      io_byte_s = snapshot_r[7:0];
         IO_LED:    io_byte_s = led_r;
         IO_STATUS: io_byte_s = status_byte(is_host_s, err_r);
         default:   io_byte_s = 8'h00;
      endcase
   end

   byte_ram #(
      .addr_width(addr_width)
   ) u_ram (
      .clk     (clk),
      .rd_en   (rd_en_s),
      .rd_addr (rd_addr_s),
      .rd_data (ram_q_s),
      .wr_en   (ram_wr_s),
      .wr_addr (wr_addr_s),
      .wr_data (wr_data_s)
   );

   // Ownership FSM; a CPU write byte pending on the deciding edge keeps the CPU for one more cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r      <= ST_CPU;
         cpu_ready_r  <= 1'b1;
         host_grant_r <= 1'b0;
      end else begin
         case (state_r)
            ST_CPU: begin
               if (host_req && !cpu_write) begin
                  state_r      <= ST_HOST;
                  cpu_ready_r  <= 1'b0;
                  host_grant_r <= 1'b1;
               end
            end
            ST_HOST: begin
               if (!host_req) begin
                  state_r      <= ST_CPU;
                  cpu_ready_r  <= 1'b1;
                  host_grant_r <= 1'b0;
               end
            end
            default: begin
               state_r      <= ST_CPU;
               cpu_ready_r  <= 1'b1;
               host_grant_r <= 1'b0;
            end
         endcase
      end
   end

   // Counter, IO registers and the one-cycle read-source pipeline that pairs with the RAM output.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         counter_r    <= 32'd0;
         snapshot_r   <= 32'd0;
         led_r        <= 8'h00;
         err_r        <= 1'b0;
         src_io_r     <= 1'b0;
         io_q_r       <= 8'h00;
         cpu_upd_r    <= 1'b0;
         host_valid_r <= 1'b0;
         cpu_last_r   <= 8'h00;
         host_last_r  <= 8'h00;
      end else begin
         counter_r <= counter_r + 32'd1;
         if (rd_en_s && rd_io_s && (rd_ofs_s == IO_CNT)) begin
            snapshot_r <= counter_r;
         end
         if (wr_en_s && wr_io_s && (wr_ofs_s == IO_LED)) begin
            led_r <= wr_data_s;
         end
         if (drop_s) begin
            err_r <= 1'b1;
         end else if (clr_s) begin
            err_r <= 1'b0;
         end
         if (rd_en_s) begin
            src_io_r <= rd_io_s;
            io_q_r   <= io_byte_s;
         end
         cpu_upd_r    <= ~is_host_s;
         host_valid_r <= is_host_s & host_read;
         cpu_last_r   <= cpu_rdata_s;
         host_last_r  <= host_rdata_s;
      end
   end

   assign rd_fresh_s   = src_io_r ? io_q_r : ram_q_s;
   assign cpu_rdata_s  = cpu_upd_r ? rd_fresh_s : cpu_last_r;
   assign host_rdata_s = host_valid_r ? rd_fresh_s : host_last_r;

   assign cpu_rdata  = cpu_rdata_s;
   assign host_rdata = host_rdata_s;
   assign cpu_ready  = cpu_ready_r;
   assign host_grant = host_grant_r;
   assign host_valid = host_valid_r;
   assign led        = led_r;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Bench for cpu_mem_responder: directed vector table, randomized traffic against a behavioural model, corner sequences.
module tb_cpu_mem_responder;

   localparam logic [8:0] IO = 9'd504;

   logic       clk = 1'b0;
   logic       reset;
   logic [8:0] cpu_raddr, cpu_waddr, host_addr;
   logic [7:0] cpu_wdata, host_wdata;
   logic       cpu_write, host_req, host_write, host_read;
   logic [7:0] cpu_rdata, host_rdata, led;
   logic       cpu_ready, host_valid, host_grant;

   cpu_mem_responder #(.addr_width(9)) dut (
      .clk(clk), .reset(reset),
      .cpu_raddr(cpu_raddr), .cpu_waddr(cpu_waddr), .cpu_wdata(cpu_wdata), .cpu_write(cpu_write),
      .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
      .host_req(host_req), .host_addr(host_addr), .host_wdata(host_wdata), .host_write(host_write),
      .host_read(host_read), .host_rdata(host_rdata), .host_valid(host_valid), .host_grant(host_grant),
      .led(led)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Behavioural model state
   logic [31:0] cnt_m;
   logic [7:0]  mem_m [0:511];
   logic [31:0] snap_m;
   logic [7:0]  led_m, cpu_m, host_m;
   logic        err_m, grant_m, valid_m;

   always @(posedge clk or posedge reset) begin
      if (reset) cnt_m <= 32'd0;
      else       cnt_m <= cnt_m + 32'd1;
   end

   typedef struct {
      logic [8:0] cra; logic [8:0] cwa; logic [7:0] cwd; logic cw;
      logic hreq; logic [8:0] ha; logic [7:0] hwd; logic hw; logic hr;
      logic e_ready; logic e_grant; logic e_valid;
      logic [7:0] e_cpu; logic [7:0] e_host; logic [7:0] e_led;
   } vec_t;

   vec_t tbl [27];

   task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] model_read(input logic [8:0] a);
      logic [8:0] o;
      if (a < IO) return mem_m[a];
      o = a - IO;
      case (o)
         9'd0: return cnt_m[31:24];
         9'd1: return snap_m[23:16];
         9'd2: return snap_m[15:8];
         9'd3: return snap_m[7:0];
         9'd4: return led_m;
         9'd5: return {6'b000000, err_m, grant_m};
         default: return 8'h00;
      endcase
   endfunction

   task automatic model_write(input logic [8:0] a, input logic [7:0] d);
      if (a < IO) mem_m[a] = d;
      else if (a == IO + 9'd4) led_m = d;
      else if (a == IO + 9'd5 && d[1]) err_m = 1'b0;
   endtask

   task automatic model_edge();
      logic       host, rd;
      logic [8:0] ra;
      logic [7:0] b;
      host = grant_m;
      ra   = host ? host_addr : cpu_raddr;
      rd   = host ? host_read : 1'b1;
      b    = 8'h00;
      if (rd) begin
         b = model_read(ra);
         if (ra == IO) snap_m = cnt_m;
      end
      if (host) begin
         if (host_write) model_write(host_addr, host_wdata);
         if (cpu_write) err_m = 1'b1;
      end else if (cpu_write) begin
         model_write(cpu_waddr, cpu_wdata);
      end
      valid_m = host & host_read;
      if (valid_m) host_m = b;
      if (!host) cpu_m = b;
      grant_m = grant_m ? host_req : (host_req & ~cpu_write);
   endtask

   task automatic step(input string tag);
      model_edge();
      @(posedge clk);
      @(negedge clk);
      check8({tag, ".cpu_rdata"},  cpu_rdata,  cpu_m);
      check8({tag, ".host_rdata"}, host_rdata, host_m);
      check8({tag, ".host_valid"}, {7'd0, host_valid}, {7'd0, valid_m});
      check8({tag, ".host_grant"}, {7'd0, host_grant}, {7'd0, grant_m});
      check8({tag, ".cpu_ready"},  {7'd0, cpu_ready},  {7'd0, ~grant_m});
      check8({tag, ".led"},        led,        led_m);
   endtask

   task automatic idle();
      cpu_raddr = IO + 9'd6; cpu_waddr = 9'd0; cpu_wdata = 8'h00; cpu_write = 1'b0;
      host_req = 1'b0; host_addr = 9'd0; host_wdata = 8'h00; host_write = 1'b0; host_read = 1'b0;
   endtask

   function automatic logic [8:0] rnd_addr();
      if ($urandom_range(0, 7) == 0) return IO + 9'($urandom_range(0, 7));
      return 9'($urandom_range(0, 503));
   endfunction

   initial begin
      tbl[0]  = '{9'h000, 9'h010, 8'hA5, 1'b1, 1'b0, 9'h000, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00};
      tbl[1]  = '{9'h010, 9'h000, 8'h00, 1'b0, 1'b0, 9'h000, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5, 8'h00, 8'h00};
      tbl[2]  = '{9'h020, 9'h020, 8'h3C, 1'b1, 1'b0, 9'h000, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00};
      tbl[3]  = '{9'h020, 9'h000, 8'h00, 1'b0, 1'b0, 9'h000, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h3C, 8'h00, 8'h00};
      tbl[4]  = '{9'h030, 9'h030, 8'h77, 1'b1, 1'b1, 9'h000, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00};
      tbl[5]  = '{9'h030, 9'h000, 8'h00, 1'b0, 1'b1, 9'h000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h77, 8'h00, 8'h00};
      tbl[6]  = '{9'h000, 9'h000, 8'h00, 1'b0, 1'b1, 9'h000, 8'h11, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h77, 8'h00, 8'h00};
      tbl[7]  = '{9'h000, 9'h000, 8'h00, 1'b0, 1'b1, 9'h001, 8'h12, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h77, 8'h00, 8'h00};
      tbl[8]  = '{9'h000, 9'h000, 8'h00, 1'b0, 1'b1, 9'h002, 8'h13, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h77, 8'h00, 8'h00};
      tbl[9]  = '{9'h000, 9'h000, 8'h00, 1'b0, 1'b1, 9'h003, 8'h14, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h77, 8'h00, 8'h00};
      tbl[10] = '{9'h000, 9'h000, 8'h00, 1'b0, 1'b1, 9'h000, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h77, 8'h11, 8'h00};
      tbl[11] = '{9'h000, 9'h000, 8'h00, 1'b0, 1'b1, 9'h001, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h77, 8'h12, 8'h00};
      tbl[12] = '{9'h000, 9'h000, 8'h00, 1'b0, 1'b1, 9'h002, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h77, 8'h13, 8'h00};
      tbl[13] = '{9'h000, 9'h000, 8'h00, 1'b0, 1'b1, 9'h003, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h77, 8'h14, 8'h00};
      tbl[14] = '{9'h000, 9'h000, 8'h00, 1'b0, 1'b1, 9'h000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h77, 8'h14, 8'h00};
      tbl[15] = '{9'h000, 9'h040, 8'hEE, 1'b1, 1'b1, 9'h000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h77, 8'h14, 8'h00};
      tbl[16] = '{9'h000, 9'h000, 8'h00, 1'b0, 1'b1, 9'h1FD, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h77, 8'h03, 8'h00};
      tbl[17] = '{9'h000, 9'h000, 8'h00, 1'b0, 1'b1, 9'h1FD, 8'h02, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h77, 8'h03, 8'h00};
      tbl[18] = '{9'h000, 9'h000, 8'h00, 1'b0, 1'b1, 9'h1FD, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h77, 8'h01, 8'h00};
      tbl[19] = '{9'h000, 9'h000, 8'h00, 1'b0, 1'b1, 9'h040, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h77, 8'h00, 8'h00};
      tbl[20] = '{9'h000, 9'h000, 8'h00, 1'b0, 1'b0, 9'h000, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h77, 8'h00, 8'h00};
      tbl[21] = '{9'h000, 9'h000, 8'h00, 1'b0, 1'b0, 9'h000, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h11, 8'h00, 8'h00};
      tbl[22] = '{9'h010, 9'h1FC, 8'h5A, 1'b1, 1'b0, 9'h000, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5, 8'h00, 8'h5A};
      tbl[23] = '{9'h1FC, 9'h000, 8'h00, 1'b0, 1'b0, 9'h000, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h5A, 8'h00, 8'h5A};
      tbl[24] = '{9'h1FD, 9'h000, 8'h00, 1'b0, 1'b0, 9'h010, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h5A};
      tbl[25] = '{9'h010, 9'h1F8, 8'h99, 1'b1, 1'b0, 9'h000, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5, 8'h00, 8'h5A};
      tbl[26] = '{9'h1F8, 9'h000, 8'h00, 1'b0, 1'b0, 9'h000, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h5A};

      for (int i = 0; i < 512; i++) mem_m[i] = 8'h00;
      snap_m = 32'd0; led_m = 8'h00; cpu_m = 8'h00; host_m = 8'h00;
      err_m = 1'b0; grant_m = 1'b0; valid_m = 1'b0;

      // Reset state
      idle();
      reset = 1'b1;
      #23;
      check8("rst.cpu_rdata",  cpu_rdata,  8'h00);
      check8("rst.host_rdata", host_rdata, 8'h00);
      check8("rst.led",        led,        8'h00);
      check8("rst.flags", {5'd0, cpu_ready, host_grant, host_valid}, 8'h04);
      @(negedge clk);
      reset = 1'b0;

      // Counter snapshot: offset 0 latches at counter 0x105, offsets 1..3 return the held snapshot
      for (int i = 0; i < 1000 && cnt_m != 32'h105; i++) @(negedge clk);
      check8("cnt.reach", cnt_m[7:0], 8'h05);
      cpu_raddr = IO + 9'd0; step("cnt0"); check8("cnt.io0", cpu_rdata, 8'h00);
      cpu_raddr = IO + 9'd1; step("cnt1"); check8("cnt.io1", cpu_rdata, 8'h00);
      cpu_raddr = IO + 9'd2; step("cnt2"); check8("cnt.io2", cpu_rdata, 8'h01);
      cpu_raddr = IO + 9'd3; step("cnt3"); check8("cnt.io3", cpu_rdata, 8'h05);

      // Give RAM a known image
      idle();
      cpu_write = 1'b1;
      for (int a = 0; a < 504; a++) begin
         cpu_waddr = 9'(a);
         step("clr");
      end
      idle();

      // Directed vector table
      for (int i = 0; i < 27; i++) begin
         cpu_raddr = tbl[i].cra; cpu_waddr = tbl[i].cwa; cpu_wdata = tbl[i].cwd; cpu_write = tbl[i].cw;
         host_req = tbl[i].hreq; host_addr = tbl[i].ha; host_wdata = tbl[i].hwd;
         host_write = tbl[i].hw; host_read = tbl[i].hr;
         step($sformatf("t%0d", i));
         check8($sformatf("t%0d.ready", i), {7'd0, cpu_ready},  {7'd0, tbl[i].e_ready});
         check8($sformatf("t%0d.grant", i), {7'd0, host_grant}, {7'd0, tbl[i].e_grant});
         check8($sformatf("t%0d.valid", i), {7'd0, host_valid}, {7'd0, tbl[i].e_valid});
         check8($sformatf("t%0d.cpu", i),  cpu_rdata,  tbl[i].e_cpu);
         check8($sformatf("t%0d.host", i), host_rdata, tbl[i].e_host);
         check8($sformatf("t%0d.led", i),  led,        tbl[i].e_led);
      end

      // Randomized traffic with host sessions coming and going
      begin
         logic req;
         req = 1'b0;
         for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) req = ~req;
            host_req   = req;
            cpu_raddr  = rnd_addr();
            cpu_waddr  = rnd_addr();
            cpu_wdata  = 8'($urandom);
            cpu_write  = ($urandom_range(0, 3) == 0);
            host_addr  = rnd_addr();
            host_wdata = 8'($urandom);
            host_write = ($urandom_range(0, 2) == 0);
            host_read  = ($urandom_range(0, 1) == 0);
            step("rnd");
         end
      end

      // Counter wrap: force 0xFFFFFFFF, then snapshot before and after the wrap
      idle();
      repeat (3) @(negedge clk);
      force dut.counter_r = 32'hFFFF_FFFF;
      @(negedge clk);
      release dut.counter_r;
      cpu_raddr = IO + 9'd0;
      @(negedge clk); check8("wrap.pre_io0", cpu_rdata, 8'hFF);
      cpu_raddr = IO + 9'd3;
      @(negedge clk); check8("wrap.pre_io3", cpu_rdata, 8'hFF);
      cpu_raddr = IO + 9'd0;
      @(negedge clk); check8("wrap.post_io0", cpu_rdata, 8'h00);
      cpu_raddr = IO + 9'd3;
      @(negedge clk); check8("wrap.post_io3", cpu_rdata, 8'h01);

      // Asynchronous reset in the middle of a host read
      idle();
      host_req = 1'b1;
      @(negedge clk);
      host_addr = IO + 9'd4; host_wdata = 8'h33; host_write = 1'b1;
      @(negedge clk);
      host_write = 1'b0; host_addr = 9'h010; host_read = 1'b1;
      @(posedge clk);
      #1;
      check8("arst.pre_valid", {7'd0, host_valid}, 8'h01);
      check8("arst.pre_led",   led, 8'h33);
      #1;
      reset = 1'b1;
      #1;
      check8("arst.valid",      {7'd0, host_valid}, 8'h00);
      check8("arst.grant",      {7'd0, host_grant}, 8'h00);
      check8("arst.ready",      {7'd0, cpu_ready},  8'h01);
      check8("arst.led",        led,        8'h00);
      check8("arst.cpu_rdata",  cpu_rdata,  8'h00);
      check8("arst.host_rdata", host_rdata, 8'h00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
